// File: rtl/text_mode_pkg.sv
// rtl/text_mode_pkg.sv - shared types and constants for the attribute text-mode generator
package text_mode_pkg;

    // Character cell layout: [7:0] code, [11:8] fg, [14:12] bg, [15] blink.
    localparam int CODE_LSB  = 0;
    localparam int ATTR_LSB  = 8;
    localparam int FG_LSB    = 8;
    localparam int BG_LSB    = 12;
    localparam int BLINK_BIT = 15;

    // Upper byte of a character cell, field order matches the bit positions above.
    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
    } cell_attr_t;

    // Per-pixel context travelling down the pipeline next to the RAM/ROM data.
    typedef struct packed {
        logic       vld;
        logic       en;
        logic       active;
        logic       in_area;
        logic       cursor;
        logic [2:0] gcol;
    } pix_ctx_t;

    // Underline cursor occupies the bottom two glyph rows.
    localparam logic [2:0] CURSOR_ROW_TOP = 3'd6;
    localparam logic [2:0] CURSOR_ROW_BOT = 3'd7;

    localparam logic [23:0] CGA_PALETTE [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

endpackage

// File: rtl/font_rom_8x8.sv
// rtl/font_rom_8x8.sv - 8x8 glyph ROM with one-cycle registered output
// Ports: clk; code (character code); row (glyph row 0..7); bits (row pattern, MSB = leftmost, valid next cycle).
module font_rom_8x8 (
    input  logic       clk,
    input  logic [7:0] code,
    input  logic [2:0] row,
    output logic [7:0] bits
);

    logic [7:0] glyph;

    // Populated glyphs: 'A', 'B' and the full block; all other codes render blank.
    always_comb begin
        glyph = 8'h00;
        case (code)
            8'h41: begin
                case (row)
                    3'd0:    glyph = 8'h30;
                    3'd1:    glyph = 8'h78;
                    3'd2:    glyph = 8'hCC;
                    3'd3:    glyph = 8'hCC;
                    3'd4:    glyph = 8'hFC;
                    3'd5:    glyph = 8'hCC;
                    3'd6:    glyph = 8'hCC;
                    default: glyph = 8'h00;
                endcase
            end
            8'h42: begin
                case (row)
                    3'd0:    glyph = 8'hFC;
                    3'd1:    glyph = 8'h66;
                    3'd2:    glyph = 8'h66;
                    3'd3:    glyph = 8'h7C;
                    3'd4:    glyph = 8'h66;
                    3'd5:    glyph = 8'h66;
                    3'd6:    glyph = 8'hFC;
                    default: glyph = 8'h00;
                endcase
            end
            8'hDB:   glyph = 8'hFF;
            default: glyph = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        bits <= glyph;
    end

endmodule

// File: rtl/text_palette16.sv
// rtl/text_palette16.sv - combinational 16-entry CGA palette lookup
// Ports: index (4-bit colour index) -> rgb (24-bit {r,g,b}).
module text_palette16
    import text_mode_pkg::*;
(
    input  logic [3:0]  index,
    output logic [23:0] rgb
);

    assign rgb = CGA_PALETTE[index];

endmodule

// File: rtl/wb_text_mode_attr.sv
// rtl/wb_text_mode_attr.sv - COLS x ROWS attribute text generator with palette, blink and underline cursor
// Ports: clk, rst_n (sync, active-low); enable; pixel_x/pixel_y/video_active/frame_start from timing;
//        cursor_en/cursor_col/cursor_row; char_addr -> external RAM, char_data <- RAM (1-cycle);
//        text_r/g/b + text_valid, 4 cycles after the pixel coordinates.
module wb_text_mode_attr
    import text_mode_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 26,
    parameter int SCALE_LOG2   = 1,
    parameter int ADDR_W       = 12,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [11:0]       pixel_x,
    input  logic [11:0]       pixel_y,
    input  logic              video_active,
    input  logic              frame_start,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [5:0]        cursor_row,
    output logic [ADDR_W-1:0] char_addr,
    input  logic [15:0]       char_data,
    output logic [7:0]        text_r,
    output logic [7:0]        text_g,
    output logic [7:0]        text_b,
    output logic              text_valid
);

    localparam int          SH         = 3 + SCALE_LOG2;
    localparam int          CS         = 8 << SCALE_LOG2;
    localparam logic [12:0] X_LIM      = 13'(COLS * CS);
    localparam logic [12:0] Y_LIM      = 13'(ROWS * CS);
    localparam int          BW         = ($clog2(BLINK_FRAMES) > 6) ? $clog2(BLINK_FRAMES) : 6;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // ---------------- S0: address generation and per-pixel context ----------------
    logic [11:0]       cell_col;
    logic [11:0]       cell_row;
    logic [2:0]        grow0;
    logic              in_area0;
    logic              cursor_row_hit;
    logic [ADDR_W-1:0] addr_calc;
    pix_ctx_t          ctx0;

    assign cell_col = pixel_x >> SH;
    assign cell_row = pixel_y >> SH;
    assign grow0    = pixel_y[SCALE_LOG2+2:SCALE_LOG2];
    assign in_area0 = ({1'b0, pixel_x} < X_LIM) && ({1'b0, pixel_y} < Y_LIM);

    // Modular arithmetic at ADDR_W bits gives the same truncated result as a wide product.
    assign addr_calc = ADDR_W'(cell_row) * ADDR_W'(COLS) + ADDR_W'(cell_col);
    assign char_addr = in_area0 ? addr_calc : '0;

    assign cursor_row_hit = (grow0 == CURSOR_ROW_TOP) || (grow0 == CURSOR_ROW_BOT);

    // Requiring in_area keeps an off-grid cursor from ever matching.
    always_comb begin
        ctx0         = '0;
        ctx0.vld     = 1'b1;
        ctx0.en      = enable;
        ctx0.active  = video_active;
        ctx0.in_area = in_area0;
        ctx0.cursor  = cursor_en && in_area0 && cursor_row_hit
                       && (cell_col == {5'd0, cursor_col})
                       && (cell_row == {6'd0, cursor_row});
        ctx0.gcol    = pixel_x[SCALE_LOG2+2:SCALE_LOG2];
    end

    // ---------------- blink timebase ----------------
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- S1..S3 pipeline ----------------
    pix_ctx_t   s1, s2, s3;
    logic [2:0] s1_grow;
    cell_attr_t attr2, attr3;
    logic [7:0] font_bits;
    logic [7:0] font3;

    // Glyph row is delayed one cycle so it meets the code returned by the RAM.
    font_rom_8x8 u_font (
        .clk  (clk),
        .code (char_data[CODE_LSB +: 8]),
        .row  (s1_grow),
        .bits (font_bits)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            s1_grow <= '0;
            attr2   <= '0;
            attr3   <= '0;
            font3   <= '0;
        end else begin
            s1      <= ctx0;
            s1_grow <= grow0;
            s2      <= s1;
            attr2   <= cell_attr_t'(char_data[ATTR_LSB +: 8]);
            s3      <= s2;
            attr3   <= attr2;
            font3   <= font_bits;
        end
    end

    // ---------------- S3: pixel select and colour resolve ----------------
    logic [23:0] fg_rgb;
    logic [23:0] bg_rgb;
    logic [23:0] rgb_next;
    logic        valid_next;
    logic        glyph_bit;

    text_palette16 u_pal_fg (
        .index (attr3.fg),
        .rgb   (fg_rgb)
    );

    text_palette16 u_pal_bg (
        .index ({1'b0, attr3.bg}),
        .rgb   (bg_rgb)
    );

    always_comb begin
        rgb_next   = 24'h000000;
        valid_next = 1'b0;
        glyph_bit  = font3[3'd7 - s3.gcol];
        if (!s3.vld || !s3.en || !s3.active) begin
            rgb_next   = 24'h000000;
            valid_next = 1'b0;
        end else if (!s3.in_area) begin
            rgb_next   = 24'h000000;
            valid_next = 1'b1;
        end else begin
            valid_next = 1'b1;
            if (s3.cursor && !blink_phase) begin
                rgb_next = fg_rgb;
            end else if (glyph_bit && !(attr3.blink && blink_phase)) begin
                rgb_next = fg_rgb;
            end else begin
                rgb_next = bg_rgb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            text_r     <= '0;
            text_g     <= '0;
            text_b     <= '0;
            text_valid <= 1'b0;
        end else begin
            text_r     <= rgb_next[23:16];
            text_g     <= rgb_next[15:8];
            text_b     <= rgb_next[7:0];
            text_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_wb_text_mode_attr.sv
// tb/tb_wb_text_mode_attr.sv - directed self-checking bench for wb_text_mode_attr
module tb_wb_text_mode_attr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] pixel_x = '0;
    logic [11:0] pixel_y = '0;
    logic        video_active = 1'b0;
    logic        frame_start = 1'b0;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic [11:0] char_addr;
    logic [15:0] char_data = '0;
    logic [7:0]  text_r, text_g, text_b;
    logic        text_valid;
    logic [15:0] ram [4096];

    logic [11:0] pixel_x2 = '0;
    logic [11:0] pixel_y2 = '0;
    logic [11:0] char_addr2;
    logic [15:0] char_data2 = '0;
    logic [7:0]  r2, g2, b2;
    logic        v2;

    int total = 0;
    int bad = 0;

    wire [23:0] rgb = {text_r, text_g, text_b};

    always #5 clk = ~clk;

    always @(posedge clk) char_data <= ram[char_addr];

    wb_text_mode_attr dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_active(video_active),
        .frame_start(frame_start), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .char_addr(char_addr), .char_data(char_data),
        .text_r(text_r), .text_g(text_g), .text_b(text_b), .text_valid(text_valid)
    );

    wb_text_mode_attr #(.COLS(40), .ROWS(30), .SCALE_LOG2(0), .ADDR_W(12), .BLINK_FRAMES(32)) dut_small (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pixel_x(pixel_x2), .pixel_y(pixel_y2), .video_active(video_active),
        .frame_start(frame_start), .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .char_addr(char_addr2), .char_data(char_data2),
        .text_r(r2), .text_g(g2), .text_b(b2), .text_valid(v2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input logic [11:0] x, input logic [11:0] y, input logic act);
        pixel_x = x;
        pixel_y = y;
        video_active = act;
        tick(4);
    endtask

    task automatic pulse_frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick(1);
            frame_start = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
        ram[0] = 16'h1F41;
        ram[1] = 16'hAF41;
        ram[5] = 16'hC720;

        tick(2);
        check("reset_rgb", 32'(rgb), 32'h000000);
        check("reset_valid", 32'(text_valid), 32'h0);

        rst_n = 1'b1;
        enable = 1'b1;

        show(0, 0, 1'b1);
        check("a_r0_c0_rgb", 32'(rgb), 32'h0000AA);
        check("a_r0_c0_valid", 32'(text_valid), 32'h1);
        show(4, 0, 1'b1);
        check("a_r0_c2", 32'(rgb), 32'hFFFFFF);
        show(6, 0, 1'b1);
        check("a_r0_c3", 32'(rgb), 32'hFFFFFF);
        show(8, 0, 1'b1);
        check("a_r0_c4", 32'(rgb), 32'h0000AA);
        show(10, 8, 1'b1);
        check("a_r4_c5", 32'(rgb), 32'hFFFFFF);
        show(12, 8, 1'b1);
        check("a_r4_c6", 32'(rgb), 32'h0000AA);

        show(0, 0, 1'b1);
        pixel_x = 12'd4;
        tick(1);
        pixel_x = 12'd0;
        tick(2);
        check("lat_before", 32'(rgb), 32'h0000AA);
        tick(1);
        check("lat_exact", 32'(rgb), 32'hFFFFFF);
        tick(1);
        check("lat_after", 32'(rgb), 32'h0000AA);

        pixel_x = 12'd1279;
        pixel_y = 12'd415;
        #1;
        check("addr_last", 32'(char_addr), 32'd2079);
        show(1280, 0, 1'b1);
        check("right_addr", 32'(char_addr), 32'd0);
        check("right_rgb", 32'(rgb), 32'h000000);
        check("right_valid", 32'(text_valid), 32'h1);
        show(0, 416, 1'b1);
        check("below_addr", 32'(char_addr), 32'd0);
        check("below_rgb", 32'(rgb), 32'h000000);
        check("below_valid", 32'(text_valid), 32'h1);

        show(4, 0, 1'b0);
        check("inactive_rgb", 32'(rgb), 32'h000000);
        check("inactive_valid", 32'(text_valid), 32'h0);

        pixel_x2 = 12'd9;
        pixel_y2 = 12'd8;
        #1;
        check("small_addr", 32'(char_addr2), 32'd41);

        cursor_col = 7'd5;
        cursor_row = 6'd0;
        cursor_en = 1'b1;
        show(80, 12, 1'b1);
        check("cur_row6", 32'(rgb), 32'hAAAAAA);
        show(80, 14, 1'b1);
        check("cur_row7", 32'(rgb), 32'hAAAAAA);
        show(80, 10, 1'b1);
        check("cur_row5", 32'(rgb), 32'hAA0000);
        cursor_en = 1'b0;
        show(80, 12, 1'b1);
        check("cur_disabled", 32'(rgb), 32'hAA0000);
        cursor_en = 1'b1;
        cursor_col = 7'd100;
        show(80, 12, 1'b1);
        check("cur_offgrid", 32'(rgb), 32'hAA0000);
        cursor_col = 7'd5;

        show(20, 0, 1'b1);
        check("blink_ph0", 32'(rgb), 32'hFFFFFF);
        pulse_frames(32);
        show(80, 12, 1'b1);
        check("cur_ph1", 32'(rgb), 32'hAA0000);
        show(20, 0, 1'b1);
        check("blink_ph1", 32'(rgb), 32'h00AA00);
        pulse_frames(32);
        show(20, 0, 1'b1);
        check("blink_ph0_again", 32'(rgb), 32'hFFFFFF);
        show(80, 12, 1'b1);
        check("cur_ph0_again", 32'(rgb), 32'hAAAAAA);

        pulse_frames(10);
        show(20, 0, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check("rst_mid_rgb", 32'(rgb), 32'h000000);
        check("rst_mid_valid", 32'(text_valid), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check($sformatf("post_rst_black%0d", k), {7'd0, text_valid, rgb}, 32'h0);
        end
        tick(1);
        check("post_rst_pix", {7'd0, text_valid, rgb}, 32'h01FFFFFF);
        pulse_frames(31);
        show(20, 0, 1'b1);
        check("blink_cnt_cleared", 32'(rgb), 32'hFFFFFF);
        pulse_frames(1);
        show(20, 0, 1'b1);
        check("blink_after_rst32", 32'(rgb), 32'h00AA00);

        enable = 1'b0;
        tick(4);
        check("disable_rgb", 32'(rgb), 32'h000000);
        check("disable_valid", 32'(text_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
